// File: rtl/keypad_if.sv
// keypad_if: pins and key-event outputs of the 3x3 keypad scanner.
// master = scanner side, slave = board/consumer side.
interface keypad_if;
  // Rows are active-low drives. Columns are pulled up, and a low column means pressed.
  // Event protocol (there is no ready, so a consumer cannot stall the scanner):
  //   bstate is high while a debounced key is held, and button carries that key code (1..9).
  //   press is a one-cycle pulse. It rises together with a rising edge of bstate.
  //   press is never high while bstate is low.
  //   button keeps its last code after release, until the next accepted press.
  logic       keypad_r1;
  logic       keypad_r2;
  logic       keypad_r3;
  logic       keypad_c1;
  logic       keypad_c2;
  logic       keypad_c3;
  logic [3:0] button;
  logic       bstate;
  logic       press;

  modport master (
    output keypad_r1, keypad_r2, keypad_r3, button, bstate, press,
    input  keypad_c1, keypad_c2, keypad_c3
  );

  modport slave (
    input  keypad_r1, keypad_r2, keypad_r3, button, bstate, press,
    output keypad_c1, keypad_c2, keypad_c3
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanning 3x3 keypad reader with frame debouncing.
// It drives one row low per slot of SCAN_DIV cycles and samples the synchronized
// columns on the last cycle of each slot.
// It builds one key code per frame (3 slots) and debounces presses and releases
// over whole frames.
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat while a key is held.
module keypad_scanner #(
  parameter int SCAN_DIV             = 12000,
  parameter int DEBOUNCE_FRAMES      = 10,
  parameter int REPEAT_DELAY_FRAMES  = 200,
  parameter int REPEAT_PERIOD_FRAMES = 50
) (
  input  logic       hwclk,
  input  logic       reset,
  keypad_if.master   kp,
  output logic [1:0] state_dbg
);

  localparam int DIV_W  = $clog2(SCAN_DIV + 1);
  localparam int MAX_A  = (DEBOUNCE_FRAMES > REPEAT_DELAY_FRAMES) ? DEBOUNCE_FRAMES : REPEAT_DELAY_FRAMES;
  localparam int MAX_F  = (MAX_A > REPEAT_PERIOD_FRAMES) ? MAX_A : REPEAT_PERIOD_FRAMES;
  // A single counter width is shared by the debounce counter and the repeat counter.
  localparam int CNT_W  = $clog2(MAX_F + 1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_DEB_PRESS   = 2'd1,
    S_HELD        = 2'd2,
    S_DEB_RELEASE = 2'd3
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       row_idx;
  logic [2:0]       c_meta;
  logic [2:0]       c_sync;
  logic [1:0]       acc_lows;
  logic [3:0]       acc_code;
  logic             frame_stb;
  logic [3:0]       frame_code;
  logic             frame_inv;
  logic [3:0]       cand;
  logic [CNT_W-1:0] frame_cnt;
  logic [3:0]       button_q;
  logic             bstate_q;
  logic             press_q;
`ifdef KEYPAD_REPEAT_EN
  logic [CNT_W-1:0] rep_cnt;
  logic             rep_first;
  logic             rep_pend;
`endif

  logic [1:0] row_lows;
  logic [1:0] row_col;
  logic [1:0] base_lows;
  logic [3:0] base_code;
  logic [2:0] lows_sum;
  logic [1:0] new_lows;
  logic [3:0] new_code;
  logic       frame_zero;
  logic       frame_is_button;
  logic       frame_is_cand;
  logic       accept_now;

  assign kp.keypad_r1 = (row_idx != 2'd0);
  assign kp.keypad_r2 = (row_idx != 2'd1);
  assign kp.keypad_r3 = (row_idx != 2'd2);
  assign kp.button    = button_q;
  assign kp.bstate    = bstate_q;
  assign kp.press     = press_q;
  assign state_dbg    = state;

  // Two-flop column synchronizer. It idles high, which reads as "not pressed".
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      c_meta <= 3'b111;
      c_sync <= 3'b111;
    end else begin
      c_meta <= {kp.keypad_c3, kp.keypad_c2, kp.keypad_c1};
      c_sync <= c_meta;
    end
  end

  // Fold the current row sample into the running frame result.
  // The low count saturates at 2, and 2 means the frame is invalid.
  always_comb begin
    row_lows = 2'd0;
    row_col  = 2'd0;
    for (int j = 0; j < 3; j++) begin
      if (!c_sync[j]) begin
        row_lows = (row_lows == 2'd2) ? 2'd2 : row_lows + 2'd1;
        row_col  = 2'(j);
      end
    end
    base_lows = (row_idx == 2'd0) ? 2'd0 : acc_lows;
    base_code = (row_idx == 2'd0) ? 4'd0 : acc_code;
    lows_sum  = {1'b0, base_lows} + {1'b0, row_lows};
    new_lows  = (lows_sum >= 3'd2) ? 2'd2 : lows_sum[1:0];
    new_code  = (row_lows == 2'd1) ? ({2'd0, row_idx} * 4'd3 + {2'd0, row_col} + 4'd1) : base_code;
  end

  // Row sequencer.
  // It samples on the last cycle of each slot and strobes a finished frame after the r3 sample.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      row_idx    <= 2'd0;
      acc_lows   <= 2'd0;
      acc_code   <= 4'd0;
      frame_stb  <= 1'b0;
      frame_code <= 4'd0;
      frame_inv  <= 1'b0;
    end else begin
      frame_stb <= 1'b0;
      if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
        div_cnt  <= '0;
        row_idx  <= (row_idx == 2'd2) ? 2'd0 : row_idx + 2'd1;
        acc_lows <= new_lows;
        acc_code <= new_code;
        if (row_idx == 2'd2) begin
          frame_stb  <= 1'b1;
          frame_code <= new_code;
          frame_inv  <= (new_lows == 2'd2);
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign frame_zero      = !frame_inv && (frame_code == 4'd0);
  assign frame_is_button = !frame_inv && (frame_code == button_q);
  assign frame_is_cand   = !frame_inv && (frame_code == cand);

  // A press is accepted on the frame that completes the debounce.
  // With DEBOUNCE_FRAMES of 1, that is the first nonzero frame seen in IDLE.
  always_comb begin
    accept_now = 1'b0;
    if (frame_stb && !frame_inv && frame_code != 4'd0) begin
      if (state == S_IDLE && DEBOUNCE_FRAMES <= 1)
        accept_now = 1'b1;
      if (state == S_DEB_PRESS && frame_is_cand && int'(frame_cnt) + 1 >= DEBOUNCE_FRAMES - 1)
        accept_now = 1'b1;
    end
  end

  // Debounce FSM. It advances only on frame strobes. All outputs are registered.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cand      <= 4'd0;
      frame_cnt <= '0;
      button_q  <= 4'd0;
      bstate_q  <= 1'b0;
      press_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b1;
      rep_pend  <= 1'b0;
`endif
    end else begin
      press_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      // The second half of a repeat: bstate was low for one cycle and now rises with press.
      if (rep_pend) begin
        rep_pend <= 1'b0;
        bstate_q <= 1'b1;
        press_q  <= 1'b1;
      end
`endif
      if (frame_stb) begin
        case (state)
          S_IDLE: begin
            if (!frame_inv && frame_code != 4'd0) begin
              cand      <= frame_code;
              frame_cnt <= '0;
              state     <= S_DEB_PRESS;
            end
          end
          S_DEB_PRESS: begin
            if (!frame_is_cand)
              state <= S_IDLE;
            else if (frame_cnt != '1)
              frame_cnt <= frame_cnt + 1'b1;
          end
          S_HELD: begin
            if (!frame_is_button) begin
              if (frame_zero && DEBOUNCE_FRAMES <= 1) begin
                state    <= S_IDLE;
                bstate_q <= 1'b0;
              end else begin
                // The frame that leaves HELD counts as the first release frame when it is empty.
                state     <= S_DEB_RELEASE;
                frame_cnt <= CNT_W'(frame_zero);
              end
            end
`ifdef KEYPAD_REPEAT_EN
            else if (int'(rep_cnt) + 1 >= (rep_first ? REPEAT_DELAY_FRAMES : REPEAT_PERIOD_FRAMES)) begin
              rep_cnt   <= '0;
              rep_first <= 1'b0;
              bstate_q  <= 1'b0;
              rep_pend  <= 1'b1;
            end else if (rep_cnt != '1) begin
              rep_cnt <= rep_cnt + 1'b1;
            end
`endif
          end
          S_DEB_RELEASE: begin
            if (frame_is_button) begin
              state <= S_HELD;
            end else if (frame_zero) begin
              if (int'(frame_cnt) + 1 >= DEBOUNCE_FRAMES) begin
                state     <= S_IDLE;
                bstate_q  <= 1'b0;
                frame_cnt <= '0;
              end else if (frame_cnt != '1) begin
                frame_cnt <= frame_cnt + 1'b1;
              end
            end else begin
              frame_cnt <= '0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
      if (accept_now) begin
        state    <= S_HELD;
        button_q <= frame_code;
        bstate_q <= 1'b1;
        press_q  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt   <= '0;
        rep_first <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 12000, meaning the number of clock cycles each row is driven (one row slot).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 10, meaning the number of consecutive identical frames needed to accept a press or a release.
REQ-003 SHALL have parameter REPEAT_DELAY_FRAMES, default 200, meaning the number of frames a key is held before the first auto-repeat.
REQ-004 SHALL have parameter REPEAT_PERIOD_FRAMES, default 50, meaning the number of frames between later auto-repeats.
REQ-005 SHALL have port hwclk, input, width 1: the single clock, 12 MHz; all logic runs on its rising edge.
REQ-006 SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-007 SHALL have ports keypad_r1, keypad_r2, keypad_r3, output, width 1 each: row drives, active-low.
REQ-008 SHALL have ports keypad_c1, keypad_c2, keypad_c3, input, width 1 each: columns, pulled up externally; low means pressed.
REQ-009 SHALL have port button, output, width 4: code of the debounced key, 1..9, or 0 for none.
REQ-010 SHALL have port bstate, output, width 1: high while a debounced key is held.
REQ-011 SHALL have port press, output, width 1: single-cycle pulse on each accepted press or repeat.

Function
REQ-012 Row scan: one row low at a time in order r1, r2, r3, then wrap to r1; each row slot lasts SCAN_DIV cycles; one frame is 3*SCAN_DIV cycles.
REQ-013 Column inputs SHALL pass through a 2-flop synchronizer; columns are sampled on the last cycle of each row slot only.
REQ-014 Frame code: exactly one low column in the frame gives code = 3*row + col + 1 (rows and columns 0-based); zero low columns gives 0; two or more low columns (ghost or multi-key) gives invalid.
REQ-015 FSM states: IDLE, DEB_PRESS, HELD, DEB_RELEASE; state is evaluated once per frame, on the cycle after the r3 sample.
REQ-016 IDLE: a valid nonzero code latches the candidate, clears frame_cnt, and moves to DEB_PRESS.
REQ-017 DEB_PRESS: the same code increments frame_cnt; when frame_cnt reaches DEBOUNCE_FRAMES-1, the FSM moves to HELD, button = candidate, bstate = 1, press = 1 for one cycle. Any other code (including invalid) returns the FSM to IDLE.
REQ-018 HELD: a frame code not equal to button (0, another key, or invalid) moves the FSM to DEB_RELEASE with frame_cnt cleared.
REQ-019 DEB_RELEASE: DEBOUNCE_FRAMES consecutive code-0 frames move the FSM to IDLE with bstate = 0; button holds its value until the next accepted press. A frame equal to button returns the FSM to HELD. Any other frame restarts the count.
REQ-020 bstate and press SHALL rise on the same cycle; press is never high while bstate is low.
REQ-021 Frame counters SHALL saturate and never wrap. Parameters of 1 SHALL mean acceptance on the first qualifying frame.

Reset
REQ-022 Reset asserted: FSM = IDLE; counters = 0; button = 0; bstate = 0; press = 0; keypad_r1 = 0; keypad_r2 = 1; keypad_r3 = 1; synchronizers = 1.
REQ-023 Reset mid-press: state is discarded; after release of reset, a still-held key needs a full DEBOUNCE_FRAMES before bstate is asserted again.

Configuration
REQ-024 Macro KEYPAD_REPEAT_EN defined: in HELD, after REPEAT_DELAY_FRAMES frames and then every REPEAT_PERIOD_FRAMES frames, bstate drops for exactly one cycle and then rises with a press pulse, giving a new rising edge to downstream edge detectors.
REQ-025 KEYPAD_REPEAT_EN undefined: no repeat logic; REPEAT_* parameters are ignored; one press pulse per physical press.

Verification
REQ-026 Bench uses SCAN_DIV=4 and DEBOUNCE_FRAMES=3. Key 5 (row 1, col 1) held steadily -> button = 5, bstate = 1, and one press pulse within 3 frames plus 2 cycles of the first detecting frame.
REQ-027 Key 9 bounces: low 1 frame, high 1 frame, then low steadily -> no press until 3 consecutive low frames; exactly one press pulse.
REQ-028 Keys 1 and 2 both held (same row) -> invalid frames; bstate stays 0; button stays 0.
REQ-029 Key 7 held, reset pulsed for 2 cycles mid-HELD -> all outputs = 0 immediately (asynchronously); bstate reasserts only after 3 new frames.
REQ-030 With KEYPAD_REPEAT_EN, REPEAT_DELAY_FRAMES=5, REPEAT_PERIOD_FRAMES=2, key 3 held 12 frames -> press pulses at debounce, at +5 frames, then every 2 frames; each repeat is preceded by a one-cycle bstate low.
REQ-031 Key 4 held then released with a 1-frame re-contact -> bstate stays 1 through the bounce and falls 3 clean zero frames after the final release.
